// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies debounced button presses into short, long/repeat and double-click events
module btn_event_decoder #(
  parameter int TICK_COUNT = 100_000,
  parameter int LONG_MS    = 1000,
  parameter int DBL_MS     = 250,
  parameter int REPEAT_MS  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_double,
  output logic o_held
);
  localparam int MAX_A  = LONG_MS > DBL_MS ? LONG_MS : DBL_MS;
  localparam int MAX_MS = MAX_A > REPEAT_MS ? MAX_A : REPEAT_MS;
  localparam int MW     = $clog2(MAX_MS + 1);
  localparam int PW     = TICK_COUNT > 1 ? $clog2(TICK_COUNT) : 1;
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED} state_t;
  state_t state;
  logic armed;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;
  logic tick, hit_long, hit_dbl, hit_rep;
  // timeouts fire on the tick that would carry ms to the limit, so they land exactly N ms after entry
  assign tick     = pre == PW'(TICK_COUNT - 1);
  assign hit_long = tick && ms == MW'(LONG_MS - 1);
  assign hit_dbl  = tick && ms == MW'(DBL_MS - 1);
  assign hit_rep  = tick && ms == MW'(REPEAT_MS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      pre      <= '0;
      ms       <= '0;
      o_press  <= 1'b0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_double <= 1'b0;
      o_held   <= 1'b0;
    end else begin
      o_press  <= 1'b0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_double <= 1'b0;
      if (!i_btn) armed <= 1'b1;
      pre <= tick ? '0 : pre + 1'b1;
      if (tick && ms != '1) ms <= ms + 1'b1;
      // every branch that changes state also clears the timebase
      case (state)
        IDLE: if (armed && i_btn) begin
          state <= PRESSED; o_press <= 1'b1; o_held <= 1'b1; pre <= '0; ms <= '0;
        end
        PRESSED: if (!i_btn) begin
          state <= WAIT_SECOND; o_held <= 1'b0; pre <= '0; ms <= '0;
        end else if (hit_long) begin
          state <= LONG_HELD; o_long <= 1'b1; pre <= '0; ms <= '0;
        end
        LONG_HELD: if (!i_btn) begin
          state <= IDLE; o_held <= 1'b0; pre <= '0; ms <= '0;
        end else if (hit_rep) begin
          o_repeat <= 1'b1; ms <= '0;
        end
        WAIT_SECOND: if (i_btn) begin
          state <= SECOND_PRESSED; o_press <= 1'b1; o_double <= 1'b1; o_held <= 1'b1; pre <= '0; ms <= '0;
        end else if (hit_dbl) begin
          state <= IDLE; o_short <= 1'b1; pre <= '0; ms <= '0;
        end
        SECOND_PRESSED: if (!i_btn) begin
          state <= IDLE; o_held <= 1'b0; pre <= '0; ms <= '0;
        end
        default: begin
          state <= IDLE; o_held <= 1'b0; pre <= '0; ms <= '0;
        end
      endcase
    end
  end
endmodule
